// File: rtl/riscv_encode_pkg.sv
// Opcodes, NOP word, immediate limits and the field bundle shared by the
// instruction encoder and its packer.
package riscv_encode_pkg;

   localparam logic [6:0]  OP_STORE        = 7'b0100011;
   localparam logic [6:0]  OP_LOAD         = 7'b0000011;
   localparam logic [6:0]  OP_BRANCH       = 7'b1100011;
   localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

   localparam int IMM12_MIN = -2048;
   localparam int IMM12_MAX = 2047;
   localparam int IMM13_MIN = -4096;
   localparam int IMM13_MAX = 4094;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } enc_req_t;

   function automatic logic in_range(input logic [31:0] imm, input int lo, input int hi);
      return ($signed(imm) >= lo) && ($signed(imm) <= hi);
   endfunction

endpackage

// File: rtl/instruction_packer.sv
// Combinational field packer: builds the S/I/B word from registered fields and
// flags any word that cannot be represented, substituting a NOP.
module instruction_packer
   import riscv_encode_pkg::*;
(
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] instr,
   output logic        err
);

   logic [31:0] word;

   always_comb begin
      word = NOP_INSTRUCTION;
      err  = 1'b1;
      case (opcode)
         OP_STORE: begin
            err  = !in_range(imm, IMM12_MIN, IMM12_MAX);
            word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         end
         OP_LOAD: begin
            err  = !in_range(imm, IMM12_MIN, IMM12_MAX);
            word = {imm[11:0], rs1, funct3, rd, opcode};
         end
         OP_BRANCH: begin
            // branch offsets are halfword-granular; bit 0 has no slot in the word
            err  = !in_range(imm, IMM13_MIN, IMM13_MAX) || imm[0];
            word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         end
         default: ;
      endcase
      instr = err ? NOP_INSTRUCTION : word;
   end

endmodule

// File: rtl/instruction_encoder.sv
// Two-stage valid/ready instruction encoder for the program loader: stage A
// holds the fields, stage B holds the packed word plus its memory address.
module instruction_encoder
   import riscv_encode_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  inValid,
   output logic                  inReady,
   input  logic [6:0]            inOpcode,
   input  logic [2:0]            inFunct3,
   input  logic [4:0]            inRd,
   input  logic [4:0]            inRs1,
   input  logic [4:0]            inRs2,
   input  logic [31:0]           inImmediate,
   output logic                  outValid,
   input  logic                  outReady,
   output logic [31:0]           outInstruction,
   output logic [ADDR_WIDTH-1:0] outAddress,
   output logic                  outError,
   output logic [7:0]            errorCount
);

   localparam int STAGES = 2;

   logic [STAGES-1:0]     vld_pipe;   // [0] stage A, [1] stage B
   enc_req_t              a_req;
   logic [31:0]           b_instr;
   logic                  b_err;
   logic [31:0]           pk_instr;
   logic                  pk_err;
   logic [ADDR_WIDTH-1:0] addr;
   logic [7:0]            err_cnt;
   logic                  a_load, b_load, out_xfer;

   assign b_load   = !vld_pipe[1] || outReady;
   assign a_load   = !vld_pipe[0] || b_load;
   assign out_xfer = vld_pipe[1] && outReady;

   instruction_packer u_packer (
      .opcode (a_req.opcode),
      .funct3 (a_req.funct3),
      .rd     (a_req.rd),
      .rs1    (a_req.rs1),
      .rs2    (a_req.rs2),
      .imm    (a_req.imm),
      .instr  (pk_instr),
      .err    (pk_err)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld_pipe <= '0;
         a_req    <= '0;
         b_instr  <= '0;
         b_err    <= 1'b0;
         addr     <= BASE_ADDR;
         err_cnt  <= '0;
      end else begin
         if (a_load) begin
            vld_pipe[0] <= inValid;
            if (inValid)
               a_req <= '{inOpcode, inFunct3, inRd, inRs1, inRs2, inImmediate};
         end
         if (b_load) begin
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) begin
               b_instr <= pk_instr;
               b_err   <= pk_err;
            end
         end
         // the counter tracks the stage-B word, so it advances only when that word leaves
         if (out_xfer) begin
            addr <= addr + ADDR_WIDTH'(1);
            if (b_err && err_cnt != 8'hFF)
               err_cnt <= err_cnt + 8'd1;
         end
      end
   end

   assign inReady        = a_load;
   assign outValid       = vld_pipe[1];
   assign outInstruction = b_instr;
   assign outAddress     = addr;
   assign outError       = b_err;
   assign errorCount     = err_cnt;

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed vectors, backpressure, address wrap,
// mid-stream reset and a randomized scoreboard against an arithmetic encoder model.
module tb_instruction_encoder;

   typedef struct packed {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } fld_t;

   typedef struct packed {
      logic [31:0] word;
      logic        err;
      logic [6:0]  op;
      logic [31:0] imm;
   } exp_t;

   typedef struct packed {
      fld_t        f;
      logic [31:0] instr;
      logic        err;
   } vec_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset, inValid, outReady, inReady, outValid, outError;
   logic [6:0]  inOpcode;
   logic [2:0]  inFunct3;
   logic [4:0]  inRd, inRs1, inRs2;
   logic [31:0] inImmediate, outInstruction;
   logic [7:0]  outAddress, errorCount;

   logic        reset2, inValid2, outReady2, inReady2, outValid2, outError2;
   logic [31:0] outInstruction2;
   logic [1:0]  outAddress2;
   logic [7:0]  errorCount2;

   instruction_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(8'd0)) dut (
      .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
      .inOpcode(inOpcode), .inFunct3(inFunct3), .inRd(inRd), .inRs1(inRs1),
      .inRs2(inRs2), .inImmediate(inImmediate), .outValid(outValid),
      .outReady(outReady), .outInstruction(outInstruction),
      .outAddress(outAddress), .outError(outError), .errorCount(errorCount)
   );

   instruction_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(2'd0)) dut2 (
      .clock(clock), .reset(reset2), .inValid(inValid2), .inReady(inReady2),
      .inOpcode(inOpcode), .inFunct3(inFunct3), .inRd(inRd), .inRs1(inRs1),
      .inRs2(inRs2), .inImmediate(inImmediate), .outValid(outValid2),
      .outReady(outReady2), .outInstruction(outInstruction2),
      .outAddress(outAddress2), .outError(outError2), .errorCount(errorCount2)
   );

   int n_cmp = 0;
   int n_bad = 0;

   exp_t sb[$];
   int   exp_addr;
   int   exp_errc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input fld_t f);
      inOpcode = f.op; inFunct3 = f.f3; inRd = f.rd;
      inRs1 = f.rs1; inRs2 = f.rs2; inImmediate = f.imm;
   endtask

   // Reference encoder: places each immediate bit by weight, straight from the format tables.
   function automatic exp_t ref_enc(input fld_t f);
      exp_t r;
      int v;
      logic [31:0] u;
      v = $signed(f.imm);
      u = f.imm;
      r.op = f.op; r.imm = f.imm; r.err = 1'b1; r.word = 32'h13;
      if (f.op == 7'h23 && v >= -2048 && v <= 2047) begin
         r.err = 1'b0;
         r.word = 32'(f.op) + (32'(f.f3) << 12) + (32'(f.rs1) << 15) + (32'(f.rs2) << 20)
                + ((u % 32) << 7) + (((u / 32) % 128) << 25);
      end else if (f.op == 7'h03 && v >= -2048 && v <= 2047) begin
         r.err = 1'b0;
         r.word = 32'(f.op) + (32'(f.rd) << 7) + (32'(f.f3) << 12) + (32'(f.rs1) << 15)
                + ((u % 4096) << 20);
      end else if (f.op == 7'h63 && v >= -4096 && v <= 4094 && (u % 2) == 0) begin
         r.err = 1'b0;
         r.word = 32'(f.op) + (32'(f.f3) << 12) + (32'(f.rs1) << 15) + (32'(f.rs2) << 20)
                + (((u / 2) % 16) << 8) + (((u / 2048) % 2) << 7)
                + (((u / 32) % 64) << 25) + (((u / 4096) % 2) << 31);
      end
      return r;
   endfunction

   // Datapath-style immediate extraction, used for the round-trip check.
   function automatic logic [31:0] extract_imm(input logic [6:0] op, input logic [31:0] w);
      if (op == 7'h23) return {{20{w[31]}}, w[31:25], w[11:7]};
      if (op == 7'h03) return {{20{w[31]}}, w[31:20]};
      return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
   endfunction

   function automatic fld_t rand_fld();
      fld_t f;
      int bnd[14] = '{-4098, -4097, -4096, -4095, -2049, -2048, -2047,
                      2046, 2047, 2048, 4093, 4094, 4095, 4096};
      logic [6:0] ops[4] = '{7'h23, 7'h03, 7'h63, 7'h00};
      f.op = ops[$urandom_range(0, 3)];
      if (f.op == 7'h00) f.op = 7'($urandom);
      f.f3 = 3'($urandom); f.rd = 5'($urandom); f.rs1 = 5'($urandom); f.rs2 = 5'($urandom);
      case ($urandom_range(0, 3))
         0: f.imm = 32'($signed($urandom_range(0, 8191)) - 4096);
         1: f.imm = 32'(bnd[$urandom_range(0, 13)]);
         2: f.imm = $urandom;
         default: f.imm = 32'(($signed($urandom_range(0, 4095)) - 2048) * 2);
      endcase
      return f;
   endfunction

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0; inValid = 1'b0; outReady = 1'b1;
      @(negedge clock);
      reset = 1'b1;
      sb.delete(); exp_addr = 0; exp_errc = 0;
   endtask

   // One scoreboard cycle on dut: drive, then predict and check everything seen this cycle.
   task automatic sb_step(input logic iv, input logic ordy, input fld_t f);
      exp_t e;
      @(negedge clock);
      apply(f); inValid = iv; outReady = ordy;
      #1;
      chk("inready_model", {31'd0, inReady}, {31'd0, !(sb.size() == 2 && !ordy)});
      if (outValid) begin
         chk("rnd_errcount", {24'd0, errorCount}, 32'(exp_errc));
         if (sb.size() == 0) begin
            chk("rnd_spurious_out", {31'd0, outValid}, 32'd0);
         end else begin
            e = sb[0];
            chk("rnd_instr", outInstruction, e.word);
            chk("rnd_err", {31'd0, outError}, {31'd0, e.err});
            chk("rnd_addr", {24'd0, outAddress}, 32'(exp_addr % 256));
            if (outReady) begin
               if (!e.err) chk("roundtrip_imm", extract_imm(e.op, outInstruction), e.imm);
               void'(sb.pop_front());
               exp_addr++;
               if (e.err && exp_errc < 255) exp_errc++;
            end
         end
      end
      if (inValid && inReady) sb.push_back(ref_enc(f));
   endtask

   task automatic drain();
      fld_t f;
      f = '0;
      for (int i = 0; i < 20 && sb.size() > 0; i++) sb_step(1'b0, 1'b1, f);
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   vec_t tbl[12];

   initial begin
      fld_t f;
      fld_t bp[3];
      logic [31:0] snap_i;
      logic [7:0]  snap_a;
      int k, got, errc;

      tbl[0]  = '{'{7'h03, 3'd3, 5'd6, 5'd10, 5'd0, 32'd2048},   32'h00000013, 1'b1};
      tbl[1]  = '{'{7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3},       32'h00000013, 1'b1};
      tbl[2]  = '{'{7'h33, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0},       32'h00000013, 1'b1};
      tbl[3]  = '{'{7'h23, 3'd3, 5'd0, 5'd2, 5'd5, 32'd16},      32'h00513823, 1'b0};
      tbl[4]  = '{'{7'h23, 3'd3, 5'd0, 5'd0, 5'd0, -32'sd2048},  32'h80003023, 1'b0};
      tbl[5]  = '{'{7'h03, 3'd3, 5'd1, 5'd0, 5'd0, 32'd2047},    32'h7FF03083, 1'b0};
      tbl[6]  = '{'{7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'd4094},    32'h7E000FE3, 1'b0};
      tbl[7]  = '{'{7'h63, 3'd0, 5'd0, 5'd0, 5'd0, -32'sd4096},  32'h80000063, 1'b0};
      tbl[8]  = '{'{7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'd4096},    32'h00000013, 1'b1};
      tbl[9]  = '{'{7'h23, 3'd3, 5'd0, 5'd0, 5'd0, -32'sd2049},  32'h00000013, 1'b1};
      tbl[10] = '{'{7'h03, 3'd3, 5'd6, 5'd10, 5'd0, -32'sd8},   32'hFF853303, 1'b0};
      tbl[11] = '{'{7'h63, 3'd0, 5'd0, 5'd1, 5'd2, -32'sd4},    32'hFE208EE3, 1'b0};

      reset = 1'b0; inValid = 1'b0; outReady = 1'b1;
      reset2 = 1'b0; inValid2 = 1'b0; outReady2 = 1'b1;
      apply('0);

      // reset state
      repeat (3) @(negedge clock);
      chk("rst_outvalid", {31'd0, outValid}, 32'd0);
      chk("rst_outaddr", {24'd0, outAddress}, 32'd0);
      chk("rst_errcount", {24'd0, errorCount}, 32'd0);
      chk("rst_instr", outInstruction, 32'd0);
      chk("rst_outerror", {31'd0, outError}, 32'd0);
      reset = 1'b1;
      @(negedge clock);
      chk("rst_inready", {31'd0, inReady}, 32'd1);

      // sd latency: presented at t0, visible after the second edge
      apply(tbl[3].f); inValid = 1'b1;
      #1 chk("sd_accept", {31'd0, inReady}, 32'd1);
      @(negedge clock); inValid = 1'b0;
      chk("sd_not_yet", {31'd0, outValid}, 32'd0);
      @(negedge clock);
      chk("sd_valid", {31'd0, outValid}, 32'd1);
      chk("sd_instr", outInstruction, 32'h00513823);
      chk("sd_addr", {24'd0, outAddress}, 32'd0);
      chk("sd_err", {31'd0, outError}, 32'd0);

      // ld then beq back-to-back
      do_reset();
      @(negedge clock); apply(tbl[10].f); inValid = 1'b1;
      @(negedge clock); apply(tbl[11].f);
      @(negedge clock); inValid = 1'b0;
      chk("ld_instr", outInstruction, 32'hFF853303);
      chk("ld_addr", {24'd0, outAddress}, 32'd0);
      @(negedge clock);
      chk("beq_valid", {31'd0, outValid}, 32'd1);
      chk("beq_instr", outInstruction, 32'hFE208EE3);
      chk("beq_addr", {24'd0, outAddress}, 32'd1);

      // table: one word at a time, running errorCount
      do_reset();
      errc = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock); apply(tbl[i].f); inValid = 1'b1;
         @(negedge clock); inValid = 1'b0;
         @(negedge clock);
         chk($sformatf("tbl%0d_valid", i), {31'd0, outValid}, 32'd1);
         chk($sformatf("tbl%0d_instr", i), outInstruction, tbl[i].instr);
         chk($sformatf("tbl%0d_err", i), {31'd0, outError}, {31'd0, tbl[i].err});
         chk($sformatf("tbl%0d_addr", i), {24'd0, outAddress}, 32'(i));
         if (tbl[i].err) errc++;
         @(negedge clock);
         chk($sformatf("tbl%0d_errcount", i), {24'd0, errorCount}, 32'(errc));
      end

      // backpressure: 3 words offered during a 5-cycle stall
      do_reset();
      for (int i = 0; i < 3; i++) begin
         bp[i] = tbl[3].f;
         bp[i].imm = 32'(4 * i);
      end
      k = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         outReady = 1'b0;
         inValid = (k < 3);
         apply(bp[k < 3 ? k : 2]);
         #1;
         if (c == 2) begin snap_i = outInstruction; snap_a = outAddress; end
         if (c == 4) begin
            chk("bp_hold_instr", outInstruction, ref_enc(bp[0]).word);
            chk("bp_hold_addr", {24'd0, outAddress}, 32'd0);
            chk("bp_hold_stable", outInstruction ^ snap_i, 32'd0);
            chk("bp_hold_stable_addr", {24'd0, outAddress ^ snap_a}, 32'd0);
         end
         if (inValid && inReady) k++;
      end
      chk("bp_accepted", 32'(k), 32'd2);
      chk("bp_inready_low", {31'd0, inReady}, 32'd0);
      got = 0;
      for (int c = 0; c < 20 && got < 3; c++) begin
         @(negedge clock);
         outReady = 1'b1;
         inValid = (k < 3);
         apply(bp[k < 3 ? k : 2]);
         #1;
         if (outValid) begin
            chk($sformatf("bp_out%0d_instr", got), outInstruction, ref_enc(bp[got]).word);
            chk($sformatf("bp_out%0d_addr", got), {24'd0, outAddress}, 32'(got));
            got++;
         end
         if (inValid && inReady) k++;
      end
      chk("bp_all_out", 32'(got), 32'd3);
      @(negedge clock); inValid = 1'b0;

      // narrow address counter wrap on dut2
      @(negedge clock);
      chk("w_rst_valid", {31'd0, outValid2}, 32'd0);
      chk("w_rst_addr", {30'd0, outAddress2}, 32'd0);
      reset2 = 1'b1;
      k = 0; got = 0;
      for (int c = 0; c < 30 && got < 5; c++) begin
         @(negedge clock);
         f = tbl[3].f; f.imm = 32'(k);
         apply(f);
         inValid2 = (k < 5); outReady2 = 1'b1;
         #1;
         if (outValid2) begin
            chk($sformatf("wrap%0d_addr", got), {30'd0, outAddress2}, 32'(got % 4));
            got++;
         end
         if (inValid2 && inReady2) k++;
      end
      chk("wrap_count", 32'(got), 32'd5);

      // reset with two words in flight
      @(negedge clock); inValid2 = 1'b1; outReady2 = 1'b0; apply(tbl[4].f);
      @(negedge clock); apply(tbl[5].f);
      @(negedge clock); inValid2 = 1'b0;
      chk("mid_inflight", {31'd0, outValid2}, 32'd1);
      reset2 = 1'b0;
      #1 chk("mid_rst_valid", {31'd0, outValid2}, 32'd0);
      @(negedge clock); reset2 = 1'b1; outReady2 = 1'b1;
      @(negedge clock); apply(tbl[3].f); inValid2 = 1'b1;
      @(negedge clock); inValid2 = 1'b0;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         #1;
         if (outValid2) begin
            chk("mid_first_instr", outInstruction2, 32'h00513823);
            chk("mid_first_addr", {30'd0, outAddress2}, 32'd0);
            got = 1;
         end else @(negedge clock);
      end
      chk("mid_first_seen", 32'(got), 32'd1);

      // randomized scoreboard run
      do_reset();
      for (int i = 0; i < 600; i++)
         sb_step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), rand_fld());
      drain();

      // errorCount saturation and 8-bit address wrap
      do_reset();
      f = tbl[2].f;
      for (int i = 0; i < 300; i++) sb_step(1'b1, 1'b1, f);
      drain();
      @(negedge clock);
      chk("sat_errcount", {24'd0, errorCount}, 32'd255);
      chk("sat_addr", {24'd0, outAddress}, 32'd44);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
